// File: rtl/ace_ccu_snoop_arb_pkg.sv
// Shared types for the CCU snoop-port arbiter: ACE snoop channel structs,
// sideband types and the CRRESP data-transfer bit.
package ace_ccu_snoop_arb_pkg;

  localparam int unsigned NUM_INIT = 2;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASK_W   = 4;
  localparam int unsigned IDX_W    = 3;

  // CRRESP[0]: the snooped cache will return a line on CD
  localparam int unsigned DataTransferBit = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        snoop;
    logic [2:0]        prot;
  } snoop_ac_t;

  typedef logic [4:0] snoop_cr_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } snoop_cd_t;

  typedef struct packed {
    logic      ac_valid;
    snoop_ac_t ac;
    logic      cr_ready;
    logic      cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic      ac_ready;
    logic      cr_valid;
    snoop_cr_t cr_resp;
    logic      cd_valid;
    snoop_cd_t cd;
  } snoop_resp_t;

  typedef logic [MASK_W-1:0] domain_mask_t;
  typedef logic [IDX_W-1:0]  mst_idx_t;

  function automatic logic has_data(snoop_cr_t resp);
    return resp[DataTransferBit];
  endfunction

endpackage

// File: rtl/ace_ccu_snoop_arb_if.sv
// Bundle of both initiator snoop ports and the shared snoop master port.
interface ace_ccu_snoop_arb_if
  import ace_ccu_snoop_arb_pkg::*;
();

  snoop_req_t   [NUM_INIT-1:0] slv_snoop_reqs_i;
  snoop_resp_t  [NUM_INIT-1:0] slv_snoop_resps_o;
  domain_mask_t [NUM_INIT-1:0] slv_masks_i;
  mst_idx_t     [NUM_INIT-1:0] slv_idx_i;
  snoop_req_t                  mst_snoop_req_o;
  snoop_resp_t                 mst_snoop_resp_i;
  domain_mask_t                mst_mask_o;
  mst_idx_t                    mst_idx_o;

  // arbiter side
  modport slave (
    input  slv_snoop_reqs_i, slv_masks_i, slv_idx_i, mst_snoop_resp_i,
    output slv_snoop_resps_o, mst_snoop_req_o, mst_mask_o, mst_idx_o
  );

  // initiators + downstream fan-out side
  modport master (
    output slv_snoop_reqs_i, slv_masks_i, slv_idx_i, mst_snoop_resp_i,
    input  slv_snoop_resps_o, mst_snoop_req_o, mst_mask_o, mst_idx_o
  );

endinterface

// File: rtl/ace_ccu_snoop_arb_fifo.sv
// Small registered FIFO (no fall-through) used to track snoop issue order
// and pending CD owners.
module ace_ccu_snoop_arb_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [2**PtrW-1:0][DataWidth-1:0] mem;
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] cnt;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt == CntW'(Depth));
  assign empty_o = (cnt == '0);
  assign data_o  = mem[rd_ptr];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/ace_ccu_snoop_arb.sv
// Shares one ACE snoop master port between the write-path (0) and read-path (1)
// snoop controllers: round-robin AC grant, in-order CR/CD return routing.
module ace_ccu_snoop_arb
  import ace_ccu_snoop_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned MaxCdPending   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ace_ccu_snoop_arb_if.slave  bus
);

  snoop_req_t  [NUM_INIT-1:0] slv_reqs;
  snoop_resp_t [NUM_INIT-1:0] slv_resps;
  snoop_req_t                 mst_req;
  snoop_resp_t                mst_resp;

  logic [NUM_INIT-1:0] ac_req;
  logic prio_q, lock_q, lock_idx_q;
  logic gnt, ac_en, ac_hs;
  logic order_full, order_empty, order_head;
  logic data_full, data_empty, data_head;
  logic head_dt, cr_fwd, cr_hs, cd_fwd, cd_done;

  assign slv_reqs              = bus.slv_snoop_reqs_i;
  assign mst_resp              = bus.mst_snoop_resp_i;
  assign bus.slv_snoop_resps_o = slv_resps;
  assign bus.mst_snoop_req_o   = mst_req;

  for (genvar i = 0; i < NUM_INIT; i++) begin : g_req
    assign ac_req[i] = slv_reqs[i].ac_valid;
  end

  // A pending (unaccepted) AC keeps its grant; otherwise prio breaks ties.
  always_comb begin
    gnt = 1'b0;
    if (lock_q)      gnt = lock_idx_q;
    else if (&ac_req) gnt = prio_q;
    else             gnt = ac_req[1];
  end

  // No AC is offered while every order slot is taken, or while in reset.
  assign ac_en   = rst_ni & ~order_full;
  assign ac_hs   = mst_req.ac_valid & mst_resp.ac_ready;

  assign head_dt = has_data(mst_resp.cr_resp);
  assign cr_fwd  = ~order_empty & ~(head_dt & data_full);
  assign cr_hs   = mst_resp.cr_valid & mst_req.cr_ready;
  assign cd_fwd  = ~data_empty;
  assign cd_done = mst_resp.cd_valid & mst_req.cd_ready & mst_resp.cd.last;

  always_comb begin
    mst_req          = '0;
    mst_req.ac_valid = ac_req[gnt] & ac_en;
    mst_req.ac       = slv_reqs[gnt].ac;
    mst_req.cr_ready = cr_fwd & slv_reqs[order_head].cr_ready;
    mst_req.cd_ready = cd_fwd & slv_reqs[data_head].cd_ready;
  end

  assign bus.mst_mask_o = bus.slv_masks_i[gnt];
  assign bus.mst_idx_o  = bus.slv_idx_i[gnt];

  always_comb begin
    slv_resps = '0;
    for (int i = 0; i < NUM_INIT; i++) begin
      slv_resps[i].ac_ready = ac_en & (gnt == 1'(i)) & mst_resp.ac_ready;
      slv_resps[i].cr_valid = cr_fwd & (order_head == 1'(i)) & mst_resp.cr_valid;
      slv_resps[i].cr_resp  = mst_resp.cr_resp;
      slv_resps[i].cd_valid = cd_fwd & (data_head == 1'(i)) & mst_resp.cd_valid;
      slv_resps[i].cd       = mst_resp.cd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
    end else if (ac_hs) begin
      prio_q <= ~gnt;
      lock_q <= 1'b0;
    end else if (mst_req.ac_valid) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt;
    end
  end

  // Issuer of every AC still awaiting its CR, oldest at the head.
  ace_ccu_snoop_arb_fifo #(
    .Depth     (MaxOutstanding),
    .DataWidth (1)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ac_hs),
    .data_i  (gnt),
    .pop_i   (cr_hs),
    .data_o  (order_head),
    .full_o  (order_full),
    .empty_o (order_empty)
  );

  // Owner of every CR that promised data and whose CD last is still due.
  ace_ccu_snoop_arb_fifo #(
    .Depth     (MaxCdPending),
    .DataWidth (1)
  ) i_data_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cr_hs & head_dt),
    .data_i  (order_head),
    .pop_i   (cd_done),
    .data_o  (data_head),
    .full_o  (data_full),
    .empty_o (data_empty)
  );

endmodule

// File: tb/tb_ace_ccu_snoop_arb.sv
// Randomized bench for ace_ccu_snoop_arb against a queue-based model of the
// issue-order / data-owner bookkeeping.
module tb_ace_ccu_snoop_arb;
  import ace_ccu_snoop_arb_pkg::*;

  localparam int MAXO  = 4;
  localparam int MAXCD = 2;
  localparam int AC_W  = $bits(snoop_ac_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ace_ccu_snoop_arb_if bus ();

  ace_ccu_snoop_arb #(
    .MaxOutstanding (MAXO),
    .MaxCdPending   (MAXCD)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state
  int q_ord[$];
  int q_dat[$];
  bit prio;
  int lock_i;
  bit pend[2];
  // per-cycle outcome captured before the clock edge
  bit m_av, m_ac_hs, m_cr_hs, m_cr_dt, m_cd_done;
  int m_g, m_cr_head;
  // stimulus knobs (percent)
  int p_req[2];
  int p_acr, p_crv, p_crr, p_cdv, p_cdr, p_dt, p_last;

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [8:0] ctl_vec();
    return {bus.mst_snoop_req_o.ac_valid, bus.mst_snoop_req_o.cr_ready,
            bus.mst_snoop_req_o.cd_ready,
            bus.slv_snoop_resps_o[1].ac_ready, bus.slv_snoop_resps_o[0].ac_ready,
            bus.slv_snoop_resps_o[1].cr_valid, bus.slv_snoop_resps_o[0].cr_valid,
            bus.slv_snoop_resps_o[1].cd_valid, bus.slv_snoop_resps_o[0].cd_valid};
  endfunction

  task automatic set_knobs(input int r0, input int r1, input int acr, input int crv,
                           input int crr, input int cdv, input int cdr, input int dt,
                           input int last);
    p_req[0] = r0; p_req[1] = r1; p_acr = acr; p_crv = crv; p_crr = crr;
    p_cdv = cdv; p_cdr = cdr; p_dt = dt; p_last = last;
  endtask

  task automatic clear_inputs();
    bus.slv_snoop_reqs_i = '0;
    bus.mst_snoop_resp_i = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
  endtask

  // Initiators hold a request (payload, mask, idx) until it is accepted.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && roll(p_req[i])) begin
        pend[i] = 1'b1;
        bus.slv_snoop_reqs_i[i].ac = AC_W'($urandom);
        bus.slv_masks_i[i]         = domain_mask_t'($urandom);
        bus.slv_idx_i[i]           = mst_idx_t'($urandom);
      end
      bus.slv_snoop_reqs_i[i].ac_valid = pend[i];
      bus.slv_snoop_reqs_i[i].cr_ready = roll(p_crr);
      bus.slv_snoop_reqs_i[i].cd_ready = roll(p_cdr);
    end
    bus.mst_snoop_resp_i.ac_ready = roll(p_acr);
    bus.mst_snoop_resp_i.cr_valid = roll(p_crv);
    bus.mst_snoop_resp_i.cr_resp  = {4'($urandom), roll(p_dt)};
    bus.mst_snoop_resp_i.cd_valid = roll(p_cdv);
    bus.mst_snoop_resp_i.cd.data  = $urandom;
    bus.mst_snoop_resp_i.cd.last  = roll(p_last);
  endtask

  task automatic compare();
    int g, h, d;
    bit full, acr, crv, dt, cr_ok, crr_h, cdv, cd_ok, cdr_d;
    logic [1:0] e_acr, e_crv, e_cdv;
    // AC
    full = (q_ord.size() == MAXO);
    if (lock_i >= 0)            g = lock_i;
    else if (pend[0] && pend[1]) g = int'(prio);
    else                        g = pend[1] ? 1 : 0;
    acr   = bus.mst_snoop_resp_i.ac_ready;
    m_av  = pend[g] && !full;
    e_acr = (!full && acr) ? 2'(1 << g) : 2'b00;
    chk("ac_valid", bus.mst_snoop_req_o.ac_valid, m_av);
    chk("ac_route", {bus.mst_snoop_req_o.ac, bus.mst_mask_o, bus.mst_idx_o},
        {bus.slv_snoop_reqs_i[g].ac, bus.slv_masks_i[g], bus.slv_idx_i[g]});
    chk("ac_ready", {bus.slv_snoop_resps_o[1].ac_ready, bus.slv_snoop_resps_o[0].ac_ready}, e_acr);
    m_ac_hs = m_av && acr;
    m_g     = g;
    // CR: routed to the oldest outstanding issuer
    h     = (q_ord.size() > 0) ? q_ord[0] : 0;
    crv   = bus.mst_snoop_resp_i.cr_valid;
    dt    = bus.mst_snoop_resp_i.cr_resp[0];
    cr_ok = (q_ord.size() > 0) && !(dt && q_dat.size() == MAXCD);
    crr_h = bus.slv_snoop_reqs_i[h].cr_ready;
    e_crv = (cr_ok && crv) ? 2'(1 << h) : 2'b00;
    chk("cr_valid", {bus.slv_snoop_resps_o[1].cr_valid, bus.slv_snoop_resps_o[0].cr_valid}, e_crv);
    chk("cr_ready", bus.mst_snoop_req_o.cr_ready, cr_ok && crr_h);
    if (cr_ok && crv)
      chk("cr_resp", bus.slv_snoop_resps_o[h].cr_resp, bus.mst_snoop_resp_i.cr_resp);
    m_cr_hs   = cr_ok && crv && crr_h;
    m_cr_dt   = dt;
    m_cr_head = h;
    // CD: routed to the oldest owner of a data-carrying CR
    d     = (q_dat.size() > 0) ? q_dat[0] : 0;
    cdv   = bus.mst_snoop_resp_i.cd_valid;
    cd_ok = (q_dat.size() > 0);
    cdr_d = bus.slv_snoop_reqs_i[d].cd_ready;
    e_cdv = (cd_ok && cdv) ? 2'(1 << d) : 2'b00;
    chk("cd_valid", {bus.slv_snoop_resps_o[1].cd_valid, bus.slv_snoop_resps_o[0].cd_valid}, e_cdv);
    chk("cd_ready", bus.mst_snoop_req_o.cd_ready, cd_ok && cdr_d);
    if (cd_ok && cdv)
      chk("cd_data", bus.slv_snoop_resps_o[d].cd, bus.mst_snoop_resp_i.cd);
    m_cd_done = cd_ok && cdv && cdr_d && bus.mst_snoop_resp_i.cd.last;
  endtask

  task automatic update();
    if (m_cd_done) void'(q_dat.pop_front());
    if (m_cr_hs) begin
      void'(q_ord.pop_front());
      if (m_cr_dt) q_dat.push_back(m_cr_head);
    end
    if (m_ac_hs) begin
      q_ord.push_back(m_g);
      prio      = (m_g == 0);
      lock_i    = -1;
      pend[m_g] = 1'b0;
    end else if (m_av) begin
      lock_i = m_g;
    end
  endtask

  task automatic step();
    drive();
    #2;
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic model_reset();
    q_ord.delete();
    q_dat.delete();
    prio   = 1'b0;
    lock_i = -1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    bus.slv_masks_i = '0;
    bus.slv_idx_i   = '0;
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // in reset: inputs active, outputs quiet, sideband from initiator 0
    bus.slv_masks_i[0] = 4'h9; bus.slv_masks_i[1] = 4'h6;
    bus.slv_idx_i[0]   = 3'd5; bus.slv_idx_i[1]   = 3'd2;
    bus.slv_snoop_reqs_i[0].ac_valid = 1'b1;
    bus.slv_snoop_reqs_i[1].ac_valid = 1'b1;
    bus.mst_snoop_resp_i.ac_ready = 1'b1;
    bus.mst_snoop_resp_i.cr_valid = 1'b1;
    bus.mst_snoop_resp_i.cd_valid = 1'b1;
    #12;
    chk("rst_ctl", ctl_vec(), 9'h0);
    chk("rst_mask", bus.mst_mask_o, 4'h9);
    chk("rst_idx", bus.mst_idx_o, 3'd5);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // initiator 1 alone
    set_knobs(0, 60, 70, 60, 70, 60, 70, 40, 30);
    run(150);
    // both contending, master always ready
    set_knobs(100, 100, 100, 70, 80, 70, 80, 30, 50);
    run(150);
    // rare ac_ready: grant lock under contention
    set_knobs(100, 100, 15, 60, 70, 60, 70, 30, 50);
    run(200);
    // slow CR: order FIFO fills
    set_knobs(90, 90, 100, 10, 60, 60, 70, 30, 50);
    run(150);
    // data-carrying CRs with stalled CD: data FIFO fills
    set_knobs(70, 70, 80, 80, 90, 60, 5, 100, 40);
    run(200);
    // mixed
    set_knobs(50, 50, 60, 50, 60, 50, 60, 50, 40);
    run(400);

    // reset in the middle of a CD burst
    set_knobs(60, 60, 80, 80, 90, 100, 100, 100, 10);
    begin
      int budget;
      budget = 300;
      while (budget > 0 && !(q_dat.size() > 0 && bus.mst_snoop_resp_i.cd_valid)) begin
        step();
        budget--;
      end
      if (budget == 0) chk("cd_burst_timeout", 1'b0, 1'b1);
    end
    drive();
    bus.mst_snoop_resp_i.cd_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", ctl_vec(), 9'h0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // after release, first contended grant goes to initiator 0
    set_knobs(100, 100, 100, 50, 50, 50, 50, 50, 50);
    drive();
    #2;
    chk("post_rst_gnt", bus.slv_snoop_resps_o[0].ac_ready, 1'b1);
    compare();
    @(posedge clk);
    update();
    #1;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
